// File: rtl/palette_fade_ctrl_if.sv
// Bus between game control / pixel pipeline and palette_fade_ctrl.
// The master drives commands, palette writes and lookups; the slave returns colour and fade status.
interface palette_fade_ctrl_if;
    logic        frame_start;
    logic        fade_cmd_valid;
    logic        fade_cmd_dir;
    logic        fade_cmd_ready;
    logic        wr_en;
    logic [2:0]  wr_index;
    logic [11:0] wr_color;
    logic [2:0]  palette_index;
    logic [11:0] color;
    logic [4:0]  fade_level;
    logic        busy;

    modport master (
        output frame_start, fade_cmd_valid, fade_cmd_dir,
        output wr_en, wr_index, wr_color, palette_index,
        input  fade_cmd_ready, color, fade_level, busy
    );

    modport slave (
        input  frame_start, fade_cmd_valid, fade_cmd_dir,
        input  wr_en, wr_index, wr_color, palette_index,
        output fade_cmd_ready, color, fade_level, busy
    );
endinterface

// File: rtl/palette_fade_ctrl.sv
// 8-entry 12-bit RGB palette with a global brightness fade that only steps on frame_start,
// so a single frame never mixes two brightness levels.
module palette_fade_ctrl #(
    parameter int STEP_FRAMES = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    palette_fade_ctrl_if.slave  bus
);

    localparam int              CNT_W     = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [4:0]      LEVEL_MAX = 5'd16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_FADE_IN  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [4:0]       level_r;
    logic [4:0]       level_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [11:0]      palette_r [8];
    logic [11:0]      color_r;

    function automatic logic [11:0] reset_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return 12'h8CF;
            3'd1:    return 12'hB86;
            3'd2:    return 12'hB74;
            3'd3:    return 12'hA75;
            3'd4:    return 12'h974;
            3'd5:    return 12'h964;
            3'd6:    return 12'h655;
            3'd7:    return 12'h432;
            default: return 12'h000;
        endcase
    endfunction

    // Level 16 multiplies by 16, so the shifted result is exactly the base channel.
    function automatic logic [3:0] scale_channel(input logic [3:0] c, input logic [4:0] lvl);
        return 4'(({5'd0, c} * {4'd0, lvl}) >> 4);
    endfunction

    function automatic logic [11:0] fade_color(input logic [11:0] c, input logic [4:0] lvl);
        return {scale_channel(c[11:8], lvl), scale_channel(c[7:4], lvl), scale_channel(c[3:0], lvl)};
    endfunction

    assign bus.fade_cmd_ready = (state_r == ST_IDLE);
    assign bus.busy           = (state_r != ST_IDLE);
    assign bus.fade_level     = level_r;
    assign bus.color          = color_r;

    // Fade state, brightness level and frame counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_IDLE;
            level_r <= LEVEL_MAX;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            level_r <= level_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Command acceptance and per-frame stepping; accept has priority over a coincident frame_start.
    always_comb begin
        state_next_s = state_r;
        level_next_s = level_r;
        cnt_next_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.fade_cmd_valid) begin
                    cnt_next_s = CNT_ZERO;
                    if (!bus.fade_cmd_dir && (level_r != 5'd0)) begin
                        state_next_s = ST_FADE_OUT;
                    end else if (bus.fade_cmd_dir && (level_r != LEVEL_MAX)) begin
                        state_next_s = ST_FADE_IN;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_FADE_OUT: begin
                if (bus.frame_start) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s   = CNT_ZERO;
                        level_next_s = level_r - 5'd1;
                        if (level_r == 5'd1) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_FADE_OUT;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_next_s = ST_FADE_OUT;
                end
            end
            ST_FADE_IN: begin
                if (bus.frame_start) begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next_s   = CNT_ZERO;
                        level_next_s = level_r + 5'd1;
                        if (level_r == (LEVEL_MAX - 5'd1)) begin
                            state_next_s = ST_IDLE;
                        end else begin
                            state_next_s = ST_FADE_IN;
                        end
                    end else begin
                        cnt_next_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_next_s = ST_FADE_IN;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                level_next_s = LEVEL_MAX;
                cnt_next_s   = CNT_ZERO;
            end
        endcase
    end

    // Base palette storage; writes land on the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < 8; i++) begin
                palette_r[i] <= reset_color(3'(i));
            end
        end else if (bus.wr_en) begin
            palette_r[bus.wr_index] <= bus.wr_color;
        end else begin
            palette_r <= palette_r;
        end
    end

    // Registered faded lookup for the pixel pipeline.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            color_r <= 12'h000;
        end else begin
            color_r <= fade_color(palette_r[bus.palette_index], level_r);
        end
    end

endmodule

// File: tb/tb_palette_fade_ctrl.sv
// Scoreboard bench: lookups push expected colours into a queue, a monitor pops and compares one cycle later.
module tb_palette_fade_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    palette_fade_ctrl_if bus_a ();
    palette_fade_ctrl_if bus_b ();

    palette_fade_ctrl #(.STEP_FRAMES(2)) dut_a (.Clk(clk), .Reset(reset), .bus(bus_a));
    palette_fade_ctrl #(.STEP_FRAMES(1)) dut_b (.Clk(clk), .Reset(reset), .bus(bus_b));

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [11:0] exp_q [$];
    string       name_q [$];
    logic        lookup_req = 1'b0;
    logic        lookup_q   = 1'b0;
    logic [11:0] base_tbl [8];

    always @(posedge clk) lookup_q <= lookup_req;

    // Monitor: a lookup sampled on the previous edge is visible on color now.
    always @(negedge clk) begin
        if (lookup_q) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_underflow: color=%03h with no expected entry", bus_a.color);
            end else begin
                logic [11:0] e;
                string       nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (bus_a.color !== e) begin
                    n_fail++;
                    $display("FAIL %s: color got %03h expected %03h", nm, bus_a.color, e);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic issue_lookup(input logic [2:0] idx, input logic [11:0] exp, input string name);
        bus_a.palette_index = idx;
        lookup_req          = 1'b1;
        exp_q.push_back(exp);
        name_q.push_back(name);
        tick();
        lookup_req = 1'b0;
    endtask

    task automatic pulse_a();
        bus_a.frame_start = 1'b1;
        tick();
        bus_a.frame_start = 1'b0;
        tick();
    endtask

    task automatic cmd_a(input logic dir);
        bus_a.fade_cmd_valid = 1'b1;
        bus_a.fade_cmd_dir   = dir;
        tick();
        bus_a.fade_cmd_valid = 1'b0;
    endtask

    initial begin
        base_tbl = '{12'h8CF, 12'hB86, 12'hB74, 12'hA75, 12'h974, 12'h964, 12'h655, 12'h432};
        reset = 1'b1;
        bus_a.frame_start = 1'b0; bus_a.fade_cmd_valid = 1'b0; bus_a.fade_cmd_dir = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_index = 3'd0; bus_a.wr_color = 12'h000; bus_a.palette_index = 3'd0;
        bus_b.frame_start = 1'b0; bus_b.fade_cmd_valid = 1'b0; bus_b.fade_cmd_dir = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_index = 3'd0; bus_b.wr_color = 12'h000; bus_b.palette_index = 3'd0;
        repeat (3) tick();
        check("rst_color", int'(bus_a.color), 32'h000);
        check("rst_level", int'(bus_a.fade_level), 16);
        check("rst_ready", int'(bus_a.fade_cmd_ready), 1);
        check("rst_busy", int'(bus_a.busy), 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) issue_lookup(3'(i), base_tbl[i], "sweep");

        // frame_start while idle must not pre-load the counter
        pulse_a();
        check("idle_pulse_level", int'(bus_a.fade_level), 16);

        bus_a.wr_en = 1'b1; bus_a.wr_index = 3'd3; bus_a.wr_color = 12'hFFF;
        issue_lookup(3'd3, 12'hA75, "wr_same_cycle_old");
        bus_a.wr_en = 1'b0;
        issue_lookup(3'd3, 12'hFFF, "wr_next_cycle_new");

        cmd_a(1'b0);
        check("fo_busy", int'(bus_a.busy), 1);
        check("fo_ready", int'(bus_a.fade_cmd_ready), 0);
        for (int k = 1; k <= 32; k++) begin
            pulse_a();
            check("fo_level", int'(bus_a.fade_level), 16 - k / 2);
            if (k == 10) begin
                bus_a.fade_cmd_valid = 1'b1; bus_a.fade_cmd_dir = 1'b1;
                tick();
                check("busy_cmd_ready", int'(bus_a.fade_cmd_ready), 0);
                bus_a.fade_cmd_valid = 1'b0;
                check("busy_cmd_level", int'(bus_a.fade_level), 11);
            end
            if (k == 16) issue_lookup(3'd0, 12'h467, "lvl8_idx0");
            if (k == 24) issue_lookup(3'd3, 12'h333, "lvl4_idx3");
            if (k == 31) check("fo_busy_lvl1", int'(bus_a.busy), 1);
        end
        check("fo_done_busy", int'(bus_a.busy), 0);
        check("fo_done_ready", int'(bus_a.fade_cmd_ready), 1);
        issue_lookup(3'd0, 12'h000, "lvl0_idx0");

        cmd_a(1'b0);
        check("noop_ready", int'(bus_a.fade_cmd_ready), 1);
        check("noop_busy", int'(bus_a.busy), 0);
        check("noop_level", int'(bus_a.fade_level), 0);

        cmd_a(1'b1);
        check("fi_busy", int'(bus_a.busy), 1);
        for (int k = 1; k <= 32; k++) begin
            pulse_a();
            check("fi_level", int'(bus_a.fade_level), k / 2);
        end
        check("fi_done_busy", int'(bus_a.busy), 0);
        issue_lookup(3'd0, 12'h8CF, "fi_idx0");

        cmd_a(1'b0);
        for (int k = 1; k <= 22; k++) pulse_a();
        check("pre_rst_level", int'(bus_a.fade_level), 5);
        reset = 1'b1;
        bus_a.palette_index = 3'd3;
        tick();
        check("midrst_color", int'(bus_a.color), 32'h000);
        check("midrst_level", int'(bus_a.fade_level), 16);
        check("midrst_ready", int'(bus_a.fade_cmd_ready), 1);
        check("midrst_busy", int'(bus_a.busy), 0);
        reset = 1'b0;
        issue_lookup(3'd3, 12'hA75, "midrst_idx3");

        // STEP_FRAMES=1: accept coincident with frame_start does not step
        bus_b.fade_cmd_valid = 1'b1; bus_b.fade_cmd_dir = 1'b0; bus_b.frame_start = 1'b1;
        tick();
        check("coinc_level", int'(bus_b.fade_level), 16);
        check("coinc_busy", int'(bus_b.busy), 1);
        bus_b.fade_cmd_valid = 1'b0;
        tick();
        check("coinc_step1", int'(bus_b.fade_level), 15);
        bus_b.frame_start = 1'b0;
        tick();
        check("coinc_hold", int'(bus_b.fade_level), 15);
        bus_b.frame_start = 1'b1;
        tick();
        check("coinc_step2", int'(bus_b.fade_level), 14);
        bus_b.frame_start = 1'b0;

        tick();
        check("sb_drain", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
